// File: rtl/prog_mem_pkg.sv
// Shared definitions for the program memory controller: FSM states, default widths
// and the all-zero exit instruction that CLEAR fills memory with.
package prog_mem_pkg;

    localparam int DEF_DATA_WIDTH = 17;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DEPTH      = 256;

    localparam logic [DEF_DATA_WIDTH-1:0] EXIT_INSTR = '0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/prog_mem_array.sv
// Program word storage: one write port and one registered read port.
// Reads beyond DEPTH return zero rather than indexing past the array.
module prog_mem_array #(
    parameter int WORD_WIDTH = 17,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  i_clk,
    input  logic                  i_resetN,
    input  logic                  i_wrEn,
    input  logic [ADDR_WIDTH-1:0] i_wrAddr,
    input  logic [WORD_WIDTH-1:0] i_wrData,
    input  logic                  i_rdEn,
    input  logic [ADDR_WIDTH-1:0] i_rdAddr,
    output logic [WORD_WIDTH-1:0] o_rdData
);

    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_rdData;
    logic                  w_rdInRange;

    assign w_rdInRange = ({1'b0, i_rdAddr} < (ADDR_WIDTH+1)'(DEPTH));

    // Contents are deliberately not reset; the controller's CLEAR pass zeroes them.
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= w_rdInRange ? r_mem[i_rdAddr] : '0;
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program memory controller: CLEAR -> LOAD -> RUN sequencing with a 1-cycle fetch port.
// Define PROG_MEM_PARITY_EN to store an even-parity bit with each word and flag fetch errors.
module prog_mem_ctrl
    import prog_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  inClk,
    input  logic                  inResetN,
    input  logic                  inLoadStart,
    input  logic [DATA_WIDTH-1:0] inLoadData,
    input  logic                  inLoadValid,
    input  logic                  inLoadLast,
    output logic                  outLoadReady,
    input  logic                  inFetchEn,
    input  logic [ADDR_WIDTH-1:0] inAddress,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outDataValid,
    output logic                  outBusy,
    output logic                  outParityErr
);

`ifdef PROG_MEM_PARITY_EN
    localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_dataValid;

    logic                  w_inLoad;
    logic                  w_accept;
    logic                  w_wrEn;
    logic [DATA_WIDTH-1:0] w_wrPayload;
    logic [WORD_WIDTH-1:0] w_wrWord;
    logic                  w_rdEn;
    logic [WORD_WIDTH-1:0] w_rdWord;

    assign w_inLoad = (r_state == ST_LOAD);
    assign w_accept = w_inLoad && inLoadValid;
    assign w_rdEn   = (r_state == ST_RUN) && inFetchEn;
    assign w_wrEn   = (r_state == ST_CLEAR) || w_accept;

    // One pointer serves both the clear sweep and the load sequence since they never overlap.
    always_ff @(posedge inClk) begin
        if (!inResetN) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_ptr == LAST_ADDR) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (inLoadValid) begin
                        if (inLoadLast || (r_ptr == LAST_ADDR)) begin
                            r_state <= ST_RUN;
                            r_ptr   <= '0;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (inLoadStart) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge inClk) begin
        if (!inResetN) begin
            r_dataValid <= 1'b0;
        end else begin
            r_dataValid <= w_rdEn;
        end
    end

    assign w_wrPayload = (r_state == ST_CLEAR) ? DATA_WIDTH'(EXIT_INSTR) : inLoadData;

`ifdef PROG_MEM_PARITY_EN
    // The all-zero clear word has even parity, so the same XOR yields parity 0 during CLEAR.
    assign w_wrWord = {^w_wrPayload, w_wrPayload};
`else
    assign w_wrWord = w_wrPayload;
`endif

    prog_mem_array #(
        .WORD_WIDTH(WORD_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .i_clk   (inClk),
        .i_resetN(inResetN),
        .i_wrEn  (w_wrEn),
        .i_wrAddr(r_ptr),
        .i_wrData(w_wrWord),
        .i_rdEn  (w_rdEn),
        .i_rdAddr(inAddress),
        .o_rdData(w_rdWord)
    );

    assign outData      = w_rdWord[DATA_WIDTH-1:0];
    assign outDataValid = r_dataValid;
    assign outLoadReady = w_inLoad;
    assign outBusy      = (r_state != ST_RUN);

`ifdef PROG_MEM_PARITY_EN
    assign outParityErr = r_dataValid && (^w_rdWord);
`else
    assign outParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Self-checking bench for prog_mem_ctrl: directed vectors plus randomized reloads and
// fetches compared against a plain array model of the program memory.
module tb_prog_mem_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        loadStart;
    logic [16:0] loadData;
    logic        loadValid;
    logic        loadLast;
    logic        fetchEn;
    logic [7:0]  address;

    logic        loadReady, dataValid, busy, parityErr;
    logic [16:0] data;
    logic        loadReady2, dataValid2, busy2, parityErr2;
    logic [16:0] data2;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] modelMem [256];
    logic [16:0] loadBuf [256];
    logic [16:0] heldData;

    typedef struct {
        logic        fetchEn;
        logic [7:0]  addr;
        logic        expValid;
        logic [16:0] expData;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    prog_mem_ctrl #(.DATA_WIDTH(17), .ADDR_WIDTH(8), .DEPTH(256)) dut (
        .inClk(clk), .inResetN(resetN), .inLoadStart(loadStart), .inLoadData(loadData),
        .inLoadValid(loadValid), .inLoadLast(loadLast), .outLoadReady(loadReady),
        .inFetchEn(fetchEn), .inAddress(address), .outData(data), .outDataValid(dataValid),
        .outBusy(busy), .outParityErr(parityErr)
    );

    prog_mem_ctrl #(.DATA_WIDTH(17), .ADDR_WIDTH(8), .DEPTH(200)) dut200 (
        .inClk(clk), .inResetN(resetN), .inLoadStart(loadStart), .inLoadData(loadData),
        .inLoadValid(loadValid), .inLoadLast(loadLast), .outLoadReady(loadReady2),
        .inFetchEn(fetchEn), .inAddress(address), .outData(data2), .outDataValid(dataValid2),
        .outBusy(busy2), .outParityErr(parityErr2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic fEn, input logic [7:0] addr,
                                 input logic valid, input logic [16:0] word, input logic last);
        loadStart = start;
        fetchEn   = fEn;
        address   = addr;
        loadValid = valid;
        loadData  = word;
        loadLast  = last;
        tick();
    endtask

    task automatic fetchCheck(input string name, input logic [7:0] addr);
        applyStimulus(1'b0, 1'b1, addr, 1'b0, 17'h0, 1'b0);
        heldData = modelMem[addr];
        checkOutput({name, "_valid"}, dataValid, 1);
        checkOutput({name, "_data"}, data, heldData);
        checkOutput({name, "_perr"}, parityErr, 0);
    endtask

    // Reload request issued together with a fetch: the fetch must still complete.
    task automatic startReload();
        logic [7:0] a;
        a = 8'($urandom_range(0, 255));
        applyStimulus(1'b1, 1'b1, a, 1'b0, 17'h0, 1'b0);
        heldData = modelMem[a];
        checkOutput("reloadFetch_valid", dataValid, 1);
        checkOutput("reloadFetch_data", data, heldData);
        checkOutput("reloadBusy", busy, 1);
        checkOutput("reloadReady", loadReady, 1);
    endtask

    task automatic loadWords(input int n, input bit withLast, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                applyStimulus(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0,
                              17'($urandom), 1'($urandom_range(0, 1)));
                checkOutput("loadGap_valid", dataValid, 0);
                checkOutput("loadGap_hold", data, heldData);
                checkOutput("loadGap_ready", loadReady, 1);
            end
            applyStimulus(1'b0, 1'b0, 8'h0, 1'b1, loadBuf[i], withLast && (i == n - 1));
            modelMem[i] = loadBuf[i];
        end
        loadValid = 1'b0;
        loadLast  = 1'b0;
        if (withLast || n == 256) begin
            checkOutput("loadDone_busy", busy, 0);
            checkOutput("loadDone_ready", loadReady, 0);
        end
    endtask

    task automatic waitClear(input string name);
        int cycles;
        cycles = 0;
        while (cycles < 300 && !loadReady) begin
            tick();
            cycles++;
        end
        checkOutput(name, cycles, 256);
    endtask

    initial begin
        resetN = 1'b0;
        loadStart = 1'b0; loadData = '0; loadValid = 1'b0; loadLast = 1'b0;
        fetchEn = 1'b0; address = '0;
        heldData = '0;
        for (int i = 0; i < 256; i++) modelMem[i] = '0;

        tick();
        tick();
        checkOutput("rst_data", data, 0);
        checkOutput("rst_valid", dataValid, 0);
        checkOutput("rst_ready", loadReady, 0);
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_perr", parityErr, 0);

        // CLEAR sweep: busy throughout, ready only after exactly 256 cycles.
        resetN = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            checkOutput($sformatf("clear_busy_%0d", i), busy, 1);
            checkOutput($sformatf("clear_ready_%0d", i), loadReady, (i == 255) ? 1 : 0);
        end

        loadBuf[0] = 17'h1E21E;
        loadBuf[1] = 17'h00001;
        loadBuf[2] = 17'h00002;
        loadWords(3, 1'b1, 1'b0);

        vecs[0] = '{1'b1, 8'd1,   1'b1, 17'h00001};
        vecs[1] = '{1'b1, 8'd5,   1'b1, 17'h00000};
        vecs[2] = '{1'b1, 8'd0,   1'b1, 17'h1E21E};
        vecs[3] = '{1'b0, 8'd2,   1'b0, 17'h1E21E};
        vecs[4] = '{1'b1, 8'd2,   1'b1, 17'h00002};
        vecs[5] = '{1'b1, 8'd255, 1'b1, 17'h00000};
        vecs[6] = '{1'b0, 8'd0,   1'b0, 17'h00000};
        vecs[7] = '{1'b1, 8'd3,   1'b1, 17'h00000};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i].fetchEn, vecs[i].addr, 1'b0, 17'h0, 1'b0);
            checkOutput($sformatf("vec%0d_valid", i), dataValid, vecs[i].expValid);
            checkOutput($sformatf("vec%0d_data", i), data, vecs[i].expData);
            checkOutput($sformatf("vec%0d_busy", i), busy, 0);
        end
        heldData = 17'h0;

        startReload();
        loadBuf[0] = 17'h0ABCD;
        loadWords(1, 1'b1, 1'b0);
        fetchCheck("reload_a0", 8'd0);
        fetchCheck("reload_a1", 8'd1);

        // Full-depth load with no last marker; the extra word must be refused.
        startReload();
        for (int i = 0; i < 256; i++) loadBuf[i] = 17'($urandom);
        loadWords(256, 1'b0, 1'b0);
        loadValid = 1'b1;
        loadData  = ~loadBuf[0];
        #1;
        checkOutput("word257_ready", loadReady, 0);
        tick();
        loadValid = 1'b0;
        checkOutput("word257_busy", busy, 0);
        fetchCheck("full_a0", 8'd0);
        fetchCheck("full_a255", 8'd255);

        applyStimulus(1'b0, 1'b1, 8'd210, 1'b0, 17'h0, 1'b0);
        heldData = modelMem[210];
        checkOutput("d200_valid", dataValid2, 1);
        checkOutput("d200_data", data2, 0);
        checkOutput("d256_a210", data, heldData);

        repeat (8) begin
            int n;
            startReload();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) loadBuf[i] = 17'($urandom);
            loadWords(n, 1'b1, 1'b1);
            repeat (20) begin
                logic       en;
                logic [7:0] a;
                en = 1'($urandom_range(0, 1));
                a  = 8'($urandom_range(0, 255));
                applyStimulus(1'b0, en, a, 1'b0, 17'h0, 1'b0);
                if (en) heldData = modelMem[a];
                checkOutput("rnd_valid", dataValid, {31'b0, en});
                checkOutput("rnd_data", data, heldData);
                checkOutput("rnd_busy", busy, 0);
            end
        end

        // Reset part-way through a load, then part-way through CLEAR.
        startReload();
        for (int i = 0; i < 5; i++) loadBuf[i] = 17'($urandom) | 17'h1;
        loadWords(5, 1'b0, 1'b0);
        resetN = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h0, 1'b1, 17'h1FFFF, 1'b0);
        checkOutput("midLoadRst_ready", loadReady, 0);
        checkOutput("midLoadRst_busy", busy, 1);
        checkOutput("midLoadRst_data", data, 0);
        resetN = 1'b1;
        loadValid = 1'b0;
        repeat (40) tick();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        waitClear("midClearRst_cycles");
        for (int i = 0; i < 256; i++) modelMem[i] = '0;
        heldData = '0;
        loadBuf[0] = 17'h01234;
        loadWords(1, 1'b1, 1'b0);
        fetchCheck("postRst_a0", 8'd0);
        fetchCheck("postRst_a1", 8'd1);
        fetchCheck("postRst_a4", 8'd4);
        fetchCheck("postRst_a100", 8'd100);
        fetchCheck("postRst_a255", 8'd255);

`ifdef PROG_MEM_PARITY_EN
        dut.u_array.r_mem[0][0] = ~dut.u_array.r_mem[0][0];
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 17'h0, 1'b0);
        checkOutput("parity_valid", dataValid, 1);
        checkOutput("parity_err", parityErr, 1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 17'h0, 1'b0);
        checkOutput("parity_idle", parityErr, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
